multi_channel_clock_divider: RTL and testbench
==============================================

// Module: multi_channel_clock_divider
// PURPOSE
//  Parametrised successor to the fixed single-output divider. It produces CHANNELS independent
//  divided clocks from masterClock. Each channel has a runtime-programmable divisor, odd and
//  even division, and a one-cycle tick strobe for use as a clock enable. Divisor reloads are
//  glitch-free and a global sync realigns all channels. It sits at the top level, feeding
//  LED/UART/PWM timing blocks.
// PARAMETERS
//  CHANNELS    4    number of independent divider channels (>=1)
//  DIV_WIDTH   16   width of the divisor and the per-channel counter
//  RESET_DIV   2    divisor loaded into every channel at reset (2..2**DIV_WIDTH-1)
// PORTS
//  masterClock  in   1                  single clock; all logic on its posedge
//  resetN       in   1                  asynchronous, active-low reset
//  chEnable     in   CHANNELS           per-channel run enable
//  syncAll      in   1                  restart all channel counters this cycle
//  wrEn         in   1                  divisor write strobe
//  wrChannel    in   max(1,$clog2(CHANNELS))  target channel of the write
//  wrDivisor    in   DIV_WIDTH          new divisor
//  dividedClock out  CHANNELS           divided clocks, registered
//  tick         out  CHANNELS           1-cycle pulse at start of each period, registered
// BEHAVIOUR
//  - Reset (async, resetN=0):
//      count=0, dividedClock=0, tick=0, divActive=RESET_DIV, pendingValid=0, all channels.
//  - Per-channel state: divActive, divPending, pendingValid, count[DIV_WIDTH-1:0].
//  - Channel runs when chEnable=1 && divActive>=2. Each running edge:
//      count <= (count==divActive-1) ? 0 : count+1;
//      dividedClock <= (count < highTime);
//      tick <= (count==0).
//    Outputs therefore lag count by one cycle. Output period is exactly divActive cycles.
//  - highTime = (divActive+1)>>1. Odd N: high (N+1)/2 cycles, low (N-1)/2 cycles.
//    Even N: exact 50% duty.
//  - Writes: wrEn loads divPending and sets pendingValid for channel wrChannel.
//    wrChannel >= CHANNELS is ignored. A second write before apply overwrites (last wins).
//  - Apply point: the pending value moves to divActive, count<=0 and pendingValid<=0 on the
//    edge where count==divActive-1 (period boundary), or immediately if the channel is
//    stopped. A new period never starts mid-cycle, so there are no runt pulses.
//  - Stopped (chEnable=0 or divActive<2): count<=0, dividedClock<=0, tick<=0.
//    Divisor 0 or 1 is legal to write and parks the channel low.
//  - syncAll=1: all channels count<=0, dividedClock<=0, tick<=0 on that edge; pending values
//    are applied. Running channels resume on the next edge in phase: tick and high level
//    appear together one edge after count returns to 0. syncAll has priority over the
//    boundary update. A write in the same cycle as syncAll is captured as pending and
//    applied at the next boundary.
//  - Enable rising: the channel starts from count=0. First tick occurs 1 cycle after the
//    first running edge.
//  - Counter wrap: count never exceeds divActive-1, so it cannot overflow DIV_WIDTH.
// CONFIGURATION
//  CLKDIV_DUTY_CFG_EN defined:
//    adds input wrHigh [DIV_WIDTH]; wrEn also captures highPending, applied together with
//    the divisor.
//    highTime = min(highActive, divActive-1); highActive=0 => output constantly low,
//    tick still pulses.
//    Reset highActive = RESET_DIV>>1.
//  CLKDIV_DUTY_CFG_EN undefined:
//    no wrHigh port; highTime fixed at (divActive+1)>>1.
// TESTING
//  1. Reset, RESET_DIV=2, all enabled -> every channel toggles each cycle; tick on every
//     2nd cycle, coincident with high.
//  2. Write ch1 div=5 while stopped, enable -> high 3 / low 2 cycles, period 5; tick once
//     per 5 cycles.
//  3. Ch0 running div=4, write div=6 at count=1 -> remaining 2 cycles at div=4, then
//     period 6; no pulse <2 cycles.
//  4. Ch0 div=4 and ch2 div=8 out of phase, pulse syncAll -> both ticks coincide 1 cycle
//     after sync, again every 8 cycles.
//  5. Write div=1 then div=0 -> output held 0, tick 0; then write 3 -> runs immediately.
//     Two writes to one channel inside a period -> only the last value appears.
//  6. Assert resetN mid-high-phase -> dividedClock and tick drop asynchronously; divisors
//     return to RESET_DIV.

Source files
------------

// File: rtl/multi_channel_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_channel_clock_divider
//   CHANNELS independent clock dividers running off masterClock. Each channel
//   has a runtime divisor, odd/even division, and a one-cycle tick strobe
//   that can be used as a clock enable. New divisors are held as pending and
//   only take effect at a period boundary, or at once when the channel is
//   stopped, so no runt pulses are produced. syncAll restarts every channel
//   in phase.
//
// Ports
//   masterClock   in   1          clock, posedge
//   resetN        in   1          async active-low reset
//   chEnable      in   CHANNELS   per-channel run enable
//   syncAll       in   1          restart all channel counters
//   wrEn          in   1          divisor write strobe
//   wrChannel     in   CW         write target (>= CHANNELS ignored)
//   wrDivisor     in   DIV_WIDTH  new divisor (0/1 park the channel low)
//   wrHigh        in   DIV_WIDTH  new high time (CLKDIV_DUTY_CFG_EN only)
//   dividedClock  out  CHANNELS   divided clocks, registered
//   tick          out  CHANNELS   1-cycle pulse at start of each period
//
// Build option
//   CLKDIV_DUTY_CFG_EN : adds wrHigh and a programmable high time per channel.
//                        Undefined: high time fixed at (divisor+1)>>1.
// ---------------------------------------------------------------------------

// One divider channel.
module clkdiv_lane #(
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 sync_i,
  input  logic                 wr_i,
  input  logic [DIV_WIDTH-1:0] wr_div_i,
`ifdef CLKDIV_DUTY_CFG_EN
  input  logic [DIV_WIDTH-1:0] wr_high_i,
`endif
  output logic                 clk_o,
  output logic                 tick_o
);
  typedef logic [DIV_WIDTH-1:0] div_t;
  localparam logic [DIV_WIDTH:0] ONE_W = (DIV_WIDTH+1)'(1);

  div_t div_q, div_d, pend_q, pend_d, cnt_q, cnt_d;
  logic pvld_q, pvld_d, clk_q, clk_d, tick_q, tick_d;
  logic run, wrap, apply;
  div_t div_m1;
  logic [DIV_WIDTH:0] high_time;

  assign div_m1 = div_q - div_t'(1);
  assign run    = en_i && (div_q >= div_t'(2));
  assign wrap   = (cnt_q == div_m1);

`ifdef CLKDIV_DUTY_CFG_EN
  div_t high_q, high_d, hpend_q, hpend_d;
  // Clamp so the output always has at least one low cycle per period.
  assign high_time = {1'b0, (high_q < div_m1) ? high_q : div_m1};
`else
  // One extra cycle of high on odd divisors.
  assign high_time = ({1'b0, div_q} + ONE_W) >> 1;
`endif

  always_comb begin
    div_d  = div_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    apply  = 1'b0;
`ifdef CLKDIV_DUTY_CFG_EN
    high_d  = high_q;
    hpend_d = hpend_q;
`endif
    if (sync_i || !run) begin
      // Stopped or realigning: park low and take any pending divisor now.
      cnt_d = '0;
      apply = pvld_q;
    end else begin
      clk_d  = ({1'b0, cnt_q} < high_time);
      tick_d = (cnt_q == '0);
      cnt_d  = wrap ? '0 : cnt_q + div_t'(1);
      apply  = wrap && pvld_q;
    end
    if (apply) begin
      div_d  = pend_q;
      pvld_d = 1'b0;
`ifdef CLKDIV_DUTY_CFG_EN
      high_d = hpend_q;
`endif
    end
    // A write on the apply edge is kept as the next pending value.
    if (wr_i) begin
      pend_d = wr_div_i;
      pvld_d = 1'b1;
`ifdef CLKDIV_DUTY_CFG_EN
      hpend_d = wr_high_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= div_t'(RESET_DIV);
      pend_q <= '0;
      pvld_q <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
`ifdef CLKDIV_DUTY_CFG_EN
      high_q  <= div_t'(RESET_DIV >> 1);
      hpend_q <= '0;
`endif
    end else begin
      div_q  <= div_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
`ifdef CLKDIV_DUTY_CFG_EN
      high_q  <= high_d;
      hpend_q <= hpend_d;
`endif
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
endmodule

module multi_channel_clock_divider #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 masterClock,
  input  logic                 resetN,
  input  logic [CHANNELS-1:0]  chEnable,
  input  logic                 syncAll,
  input  logic                 wrEn,
  input  logic [CW-1:0]        wrChannel,
  input  logic [DIV_WIDTH-1:0] wrDivisor,
`ifdef CLKDIV_DUTY_CFG_EN
  input  logic [DIV_WIDTH-1:0] wrHigh,
`endif
  output logic [CHANNELS-1:0]  dividedClock,
  output logic [CHANNELS-1:0]  tick
);
  logic [CHANNELS-1:0] wr_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    // Out-of-range channel numbers match no lane and are dropped.
    assign wr_hit[g] = wrEn && (wrChannel == CW'(g));

    clkdiv_lane #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_lane (
      .clk_i     (masterClock),
      .rst_ni    (resetN),
      .en_i      (chEnable[g]),
      .sync_i    (syncAll),
      .wr_i      (wr_hit[g]),
      .wr_div_i  (wrDivisor),
`ifdef CLKDIV_DUTY_CFG_EN
      .wr_high_i (wrHigh),
`endif
      .clk_o     (dividedClock[g]),
      .tick_o    (tick[g])
    );
  end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
module tb_multi_channel_clock_divider;
  localparam int CH = 4;
  localparam int DW = 16;

  logic          masterClock = 1'b0;
  logic          resetN;
  logic [CH-1:0] chEnable;
  logic          syncAll;
  logic          wrEn;
  logic [1:0]    wrChannel;
  logic [DW-1:0] wrDivisor;
`ifdef CLKDIV_DUTY_CFG_EN
  logic [DW-1:0] wrHigh = '0;
`endif
  logic [CH-1:0] dividedClock;
  logic [CH-1:0] tick;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] cs [CH];
  logic [31:0] ts [CH];

  multi_channel_clock_divider #(.CHANNELS(CH), .DIV_WIDTH(DW), .RESET_DIV(2)) dut (
    .masterClock  (masterClock),
    .resetN       (resetN),
    .chEnable     (chEnable),
    .syncAll      (syncAll),
    .wrEn         (wrEn),
    .wrChannel    (wrChannel),
    .wrDivisor    (wrDivisor),
`ifdef CLKDIV_DUTY_CFG_EN
    .wrHigh       (wrHigh),
`endif
    .dividedClock (dividedClock),
    .tick         (tick)
  );

  always #5 masterClock = ~masterClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge masterClock);
    #1;
  endtask

  // Record n cycles of every channel, first sample ends up in the MSB.
  task automatic cap(input int n);
    for (int c = 0; c < CH; c++) begin
      cs[c] = '0;
      ts[c] = '0;
    end
    repeat (n) begin
      step();
      for (int c = 0; c < CH; c++) begin
        cs[c] = {cs[c][30:0], dividedClock[c]};
        ts[c] = {ts[c][30:0], tick[c]};
      end
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [DW-1:0] d);
    wrEn = 1'b1;
    wrChannel = ch;
    wrDivisor = d;
    step();
    wrEn = 1'b0;
  endtask

  initial begin
    logic found;
    resetN = 1'b0; chEnable = 4'hF; syncAll = 1'b0;
    wrEn = 1'b0; wrChannel = '0; wrDivisor = '0;

    // 1: reset state, then divide-by-2 on every channel
    repeat (3) step();
    chk("rst_clk", 32'(dividedClock), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    resetN = 1'b1;
    step();
    chk("d2_first_clk", 32'(dividedClock), 32'hF);
    chk("d2_first_tick", 32'(tick), 32'hF);
    step();
    chk("d2_second_clk", 32'(dividedClock), 32'h0);
    cap(6);
    chk("d2_ch3_clk", cs[3], 32'b101010);
    chk("d2_ch3_tick", ts[3], 32'b101010);

    // 2: ch1 programmed to 5 while stopped
    chEnable = 4'b1101;
    step();
    wr(2'd1, 16'd5);
    chk("stop_ch1_low", 32'(dividedClock[1]), 32'h0);
    step();
    chEnable = 4'hF;
    cap(10);
    chk("d5_clk", cs[1], 32'b1110011100);
    chk("d5_tick", ts[1], 32'b1000010000);

    // 3: ch0 at 4, reprogram to 6 mid-period
    chEnable = 4'b1110;
    step();
    wr(2'd0, 16'd4);
    step();
    chEnable = 4'hF;
    step();
    chk("d4_start_clk", 32'(dividedClock[0]), 32'h1);
    chk("d4_start_tick", 32'(tick[0]), 32'h1);
    wr(2'd0, 16'd6);
    chk("d4_cnt1_clk", 32'(dividedClock[0]), 32'h1);
    chk("d4_cnt1_tick", 32'(tick[0]), 32'h0);
    cap(9);
    chk("reload_clk", cs[0], 32'b001110001);
    chk("reload_tick", ts[0], 32'b001000001);

    // 4: ch0=4, ch2=8, then syncAll realigns them
    wr(2'd0, 16'd4);
    wr(2'd2, 16'd8);
    repeat (15) step();
    syncAll = 1'b1;
    step();
    syncAll = 1'b0;
    chk("sync_clk", 32'(dividedClock), 32'h0);
    chk("sync_tick", 32'(tick), 32'h0);
    cap(16);
    chk("sync_ch0_clk", cs[0], 32'b1100110011001100);
    chk("sync_ch0_tick", ts[0], 32'b1000100010001000);
    chk("sync_ch2_clk", cs[2], 32'b1111000011110000);
    chk("sync_ch2_tick", ts[2], 32'b1000000010000000);

    // 5: divisor 1 and 0 park ch3, then 3 restarts it
    wr(2'd3, 16'd1);
    repeat (3) step();
    cap(4);
    chk("d1_clk", cs[3], 32'h0);
    chk("d1_tick", ts[3], 32'h0);
    wr(2'd3, 16'd0);
    cap(4);
    chk("d0_clk", cs[3], 32'h0);
    chk("d0_tick", ts[3], 32'h0);
    wr(2'd3, 16'd3);
    cap(7);
    chk("d3_clk", cs[3], 32'b0110110);
    chk("d3_tick", ts[3], 32'b0100100);

    // 5b: two writes inside one period, last one wins
    syncAll = 1'b1;
    step();
    syncAll = 1'b0;
    wr(2'd1, 16'd7);
    wr(2'd1, 16'd3);
    cap(9);
    chk("last_wins_clk", cs[1], 32'b100110110);
    chk("last_wins_tick", ts[1], 32'b000100100);

    // 6: async reset during the high phase of ch1
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (dividedClock[1]) found = 1'b1;
      else step();
    end
    chk("find_high", 32'(found), 32'h1);
    resetN = 1'b0;
    #1;
    chk("async_rst_clk", 32'(dividedClock), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    step();
    resetN = 1'b1;
    cap(4);
    chk("post_rst_ch1_clk", cs[1], 32'b1010);
    chk("post_rst_ch1_tick", ts[1], 32'b1010);
    chk("post_rst_ch2_clk", cs[2], 32'b1010);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
